rr_arbiter8: RTL and testbench

Round-robin arbiter that shares one resource among eight requesters and produces a registered one-hot grant plus its 3-bit encoded index. A grant is held until the owner signals completion, drops its request, or exceeds a hold limit; the arbiter then inserts a one-cycle release bubble and rotates priority. It sits between the request lines and the shared datapath, and drives that datapath's select with `grant_id`.

---
 rtl/rr_arbiter8_pkg.sv | 28 ++
 rtl/rr_arbiter8_onehot8_encode.sv | 18 +
 rtl/rr_arbiter8.sv | 85 ++++++++
 tb/tb_rr_arbiter8.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/rr_arbiter8_pkg.sv
// rr_arbiter8_pkg: shared constants, FSM state type and rotate helpers
// for the eight-way round-robin arbiter.
package rr_arbiter8_pkg;

   localparam int NUM_REQ = 8;
   localparam int ID_W    = 3;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_GRANT,
      ST_RELEASE
   } state_e;

   function automatic logic [NUM_REQ-1:0] rot_right(input logic [NUM_REQ-1:0] v,
                                                    input logic [ID_W-1:0]    n);
      logic [2*NUM_REQ-1:0] w;
      w = {v, v} >> n;
      return w[NUM_REQ-1:0];
   endfunction

   function automatic logic [NUM_REQ-1:0] rot_left(input logic [NUM_REQ-1:0] v,
                                                   input logic [ID_W-1:0]    n);
      logic [2*NUM_REQ-1:0] w;
      w = {v, v} << n;
      return w[2*NUM_REQ-1:NUM_REQ];
   endfunction

endpackage

// File: rtl/rr_arbiter8_onehot8_encode.sv
// onehot8_encode: combinational one-hot to binary index; anything that is
// not exactly one-hot yields index 0 with valid low.
module onehot8_encode
   import rr_arbiter8_pkg::*;
(
   input  logic [NUM_REQ-1:0] onehot,
   output logic [ID_W-1:0]    idx,
   output logic               valid
);

   always_comb begin
      valid = $onehot(onehot);
      idx   = '0;
      for (int i = 0; i < NUM_REQ; i++)
         if (valid && onehot[i]) idx = ID_W'(i);
   end

endmodule

// File: rtl/rr_arbiter8.sv
// rr_arbiter8: round-robin arbiter for eight requesters with registered grant,
// hold limit with timeout pulse, and a one-cycle release bubble.
module rr_arbiter8
   import rr_arbiter8_pkg::*;
#(
   parameter int unsigned MAX_HOLD = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_REQ-1:0] req,
   input  logic               done,
   output logic [NUM_REQ-1:0] grant,
   output logic [ID_W-1:0]    grant_id,
   output logic               grant_valid,
   output logic               timeout
);

   localparam int            HW        = $clog2(MAX_HOLD);
   localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

   state_e             state_q, state_d;
   logic [ID_W-1:0]    last_q, last_d;
   logic [HW-1:0]      hold_q, hold_d;
   logic [NUM_REQ-1:0] grant_q, grant_d;
   logic [ID_W-1:0]    grant_id_q, grant_id_d;
   logic               grant_valid_q, grant_valid_d;
   logic               timeout_q, timeout_d;

   logic [ID_W-1:0]    start;
   logic [NUM_REQ-1:0] req_rot, pick_rot, winner;
   logic               owner_req, hold_lim, release_now;

   // Rotate so last+1 sits at bit 0, take the lowest set bit, rotate back.
   always_comb begin
      start       = last_q + ID_W'(1);
      req_rot     = rot_right(req, start);
      pick_rot    = req_rot & (~req_rot + NUM_REQ'(1));
      winner      = rot_left(pick_rot, start);
      owner_req   = req[grant_id_q];
      hold_lim    = hold_q == HOLD_LAST;
      release_now = (state_q == ST_GRANT) && (done || !owner_req || hold_lim);
      state_d     = (state_q == ST_IDLE)  ? ((|req) ? ST_GRANT : ST_IDLE) :
                    (state_q == ST_GRANT) ? (release_now ? ST_RELEASE : ST_GRANT) :
                                            ST_IDLE;
      grant_d     = (state_q == ST_IDLE) ? winner :
                    (state_q == ST_GRANT && !release_now) ? grant_q : '0;
      hold_d      = (state_q != ST_GRANT) ? '0 :
                    hold_lim ? hold_q : hold_q + HW'(1);
      last_d      = release_now ? grant_id_q : last_q;
      // A coincident done or dropped request makes it a normal release.
      timeout_d   = release_now && hold_lim && !done && owner_req;
   end

   onehot8_encode u_enc (
      .onehot (grant_d),
      .idx    (grant_id_d),
      .valid  (grant_valid_d)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         last_q        <= '1;
         hold_q        <= '0;
         grant_q       <= '0;
         grant_id_q    <= '0;
         grant_valid_q <= 1'b0;
         timeout_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         last_q        <= last_d;
         hold_q        <= hold_d;
         grant_q       <= grant_d;
         grant_id_q    <= grant_id_d;
         grant_valid_q <= grant_valid_d;
         timeout_q     <= timeout_d;
      end
   end

   assign grant       = grant_q;
   assign grant_id    = grant_id_q;
   assign grant_valid = grant_valid_q;
   assign timeout     = timeout_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// tb_rr_arbiter8: scoreboard bench; a behavioural arbiter model queues the
// expected outputs of each cycle and they are compared after the clock edge.
module tb_rr_arbiter8;

   localparam int MAX_HOLD = 4;

   logic       clk, rst_n, done;
   logic [7:0] req, grant;
   logic [2:0] grant_id;
   logic       grant_valid, timeout;

   rr_arbiter8 #(.MAX_HOLD(MAX_HOLD)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req         (req),
      .done        (done),
      .grant       (grant),
      .grant_id    (grant_id),
      .grant_valid (grant_valid),
      .timeout     (timeout)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] g;
      logic [2:0] id;
      logic       v;
      logic       to;
   } exp_t;

   exp_t q[$];
   int   n_chk = 0, n_pass = 0;
   int   m_state, m_own, m_hold, m_last;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic model(input logic [7:0] r, input logic d, output exp_t e);
      bit found;
      int i;
      e = '0;
      found = 0;
      if (m_state == 0) begin
         for (int k = 1; k <= 8; k++) begin
            i = (m_last + k) % 8;
            if (!found && r[i]) begin
               found = 1;
               m_own = i;
            end
         end
         if (found) begin
            m_state = 1;
            m_hold  = 0;
            e.g  = 8'(1 << m_own);
            e.id = 3'(m_own);
            e.v  = 1'b1;
         end
      end else if (m_state == 1) begin
         if (d || !r[m_own] || m_hold == MAX_HOLD - 1) begin
            e.to    = (m_hold == MAX_HOLD - 1) && !d && r[m_own];
            m_state = 2;
            m_last  = m_own;
         end else begin
            m_hold++;
            e.g  = 8'(1 << m_own);
            e.id = 3'(m_own);
            e.v  = 1'b1;
         end
      end else begin
         m_state = 0;
      end
   endtask

   task automatic step(input logic [7:0] r, input logic d);
      exp_t e;
      req  = r;
      done = d;
      model(r, d, e);
      q.push_back(e);
      @(posedge clk);
      #1;
      e = q.pop_front();
      check("grant", 32'(grant), 32'(e.g));
      check("grant_id", 32'(grant_id), 32'(e.id));
      check("grant_valid", 32'(grant_valid), 32'(e.v));
      check("timeout", 32'(timeout), 32'(e.to));
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      check("rst_grant", 32'(grant), 32'h0);
      check("rst_grant_id", 32'(grant_id), 32'h0);
      check("rst_valid", 32'(grant_valid), 32'h0);
      check("rst_timeout", 32'(timeout), 32'h0);
      m_state = 0;
      m_own   = 0;
      m_hold  = 0;
      m_last  = 7;
      q.delete();
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      int ids[$];
      int nv, nt;
      clk  = 1'b0;
      req  = '0;
      done = 1'b0;
      rst_n = 1'b1;
      #2;
      do_reset();

      // single requester, done pulse, two-cycle bubble, re-grant
      step(8'h01, 1'b0);
      check("t1_grant", 32'(grant), 32'h01);
      step(8'h01, 1'b1);
      step(8'h01, 1'b0);
      check("t1_bubble_idle", 32'(grant_valid), 32'h0);
      step(8'h01, 1'b0);
      check("t1_regrant", 32'(grant), 32'h01);
      step(8'h00, 1'b0);

      // all requesting, one-cycle grants rotate 0..7,0
      do_reset();
      for (int s = 0; s < 27; s++) begin
         step(8'hFF, m_state == 1);
         if (grant_valid) ids.push_back(int'(grant_id));
      end
      check("t2_ngrants", 32'(ids.size()), 32'd9);
      foreach (ids[k]) check("t2_id", 32'(ids[k]), 32'(k % 8));

      // hold limit: 4 grant cycles, one timeout, then re-grant of 3
      do_reset();
      nv = 0;
      nt = 0;
      for (int s = 0; s < 6; s++) begin
         step(8'h08, 1'b0);
         nv += int'(grant_valid);
         nt += int'(timeout);
      end
      check("t3_hold_cycles", 32'(nv), 32'd4);
      check("t3_timeouts", 32'(nt), 32'd1);
      step(8'h08, 1'b0);
      check("t3_regrant", 32'(grant), 32'h08);

      // done coincides with the limit
      do_reset();
      for (int s = 0; s < 4; s++) step(8'h08, 1'b0);
      step(8'h08, 1'b1);
      check("t4_done_lim_to", 32'(timeout), 32'h0);
      check("t4_done_lim_g", 32'(grant), 32'h0);

      // request drop coincides with the limit
      do_reset();
      for (int s = 0; s < 4; s++) step(8'h08, 1'b0);
      step(8'h00, 1'b0);
      check("t4_drop_lim_to", 32'(timeout), 32'h0);

      // owner 5 drops; next goes to 2 when 6,7,0,1 idle
      do_reset();
      step(8'h20, 1'b0);
      check("t5_owner5", 32'(grant_id), 32'd5);
      step(8'h24, 1'b0);
      step(8'h04, 1'b0);
      step(8'h04, 1'b0);
      step(8'h04, 1'b0);
      check("t5_next2", 32'(grant_id), 32'd2);
      // with 7 also requesting after owner 5, 7 wins over 2
      do_reset();
      step(8'h20, 1'b0);
      step(8'h84, 1'b0);
      step(8'h84, 1'b0);
      step(8'h84, 1'b0);
      check("t5_next7", 32'(grant_id), 32'd7);

      // reset mid-grant restores requester 4 priority over 5
      do_reset();
      step(8'h30, 1'b0);
      check("t6_first4", 32'(grant_id), 32'd4);
      step(8'h20, 1'b0);
      step(8'h30, 1'b0);
      step(8'h30, 1'b0);
      check("t6_then5", 32'(grant_id), 32'd5);
      step(8'h30, 1'b0);
      do_reset();
      step(8'h30, 1'b0);
      check("t6_after_rst4", 32'(grant_id), 32'd4);
      check("t6_no_timeout", 32'(timeout), 32'h0);
      step(8'h30, 1'b1);
      step(8'h00, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
